// File: rtl/adc_stream_framer_pkg.sv
// Shared types and helpers for the ADC sample framer: FSM state encoding,
// bytes-per-sample sizing and the default frame marker.
package adc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_e;

  localparam logic [7:0] DEF_SYNC = 8'hA5;

  function automatic int bytes_per_sample(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/adc_stream_framer_sync_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after rd_en_i).
// Pointers carry one extra MSB so full and empty can be told apart.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = rdata_q;

  assign do_rd = rd_en_i && !empty_o;
  // A push into a full FIFO is still taken when a pop frees a slot this cycle.
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/adc_stream_framer.sv
// Buffers tagged ADC samples and serialises each one to a byte UART, either
// as raw data bytes or as a SYNC/CH/DATA/XOR-checksum frame.
module adc_stream_framer
  import adc_stream_pkg::*;
#(
  parameter int         DATA_W     = 12,
  parameter int         NUM_CH     = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC,
  localparam int        CH_W       = $clog2(NUM_CH),
  localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_strobe,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]   s_ch,
  input  logic              frame_mode,
  output logic              uart_en_send,
  output logic [7:0]        uart_data,
  input  logic              uart_tx_done,
  output logic [LW-1:0]     fifo_level,
  output logic [7:0]        overflow_cnt,
  output logic              busy,
  output state_e            dbg_state_o
);

  localparam int NB = bytes_per_sample(DATA_W);
  localparam int EW = CH_W + DATA_W;

  // UART handshake: uart_en_send is a one-cycle pulse with uart_data valid in
  // that same cycle; the UART answers with a one-cycle uart_tx_done pulse, and
  // only one byte is ever outstanding, so tx_done is only honoured in WAIT.

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            mode_q;
  logic [NB*8-1:0] data_q;
  logic [7:0]      chb_q;
  logic [7:0]      cs_q;
  logic [7:0]      ovf_q;

  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_rdata;
  logic [NB*8-1:0] ld_ext;
  logic [7:0]      ld_chb;
  logic [7:0]      ld_cs;
  logic [2:0]      last_idx;
  logic [7:0]      tx_byte;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (s_strobe),
    .wdata_i ({s_ch, s_data}),
    .rd_en_i (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    ld_ext             = '0;
    ld_ext[DATA_W-1:0] = fifo_rdata[DATA_W-1:0];
    ld_chb             = 8'(fifo_rdata[DATA_W +: CH_W]);
    ld_cs              = ld_chb;
    for (int k = 0; k < NB; k++) begin
      ld_cs = ld_cs ^ ld_ext[k*8 +: 8];
    end
  end

  assign last_idx = mode_q ? 3'(NB + 2) : 3'(NB - 1);

  // Framed order is SYNC, CHB, data MSB byte first, checksum; raw is data only.
  always_comb begin
    tx_byte = 8'h00;
    if (mode_q) begin
      if (idx_q == 3'd0) begin
        tx_byte = SYNC_BYTE;
      end else if (idx_q == 3'd1) begin
        tx_byte = chb_q;
      end else if (idx_q == last_idx) begin
        tx_byte = cs_q;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (idx_q == 3'(NB + 1 - k)) tx_byte = data_q[k*8 +: 8];
        end
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (idx_q == 3'(NB - 1 - k)) tx_byte = data_q[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pop          = 1'b0;
    uart_en_send = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        uart_en_send = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (uart_tx_done) begin
          if (idx_q == last_idx) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      chb_q   <= 8'h00;
      cs_q    <= 8'h00;
      ovf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Mode is sampled once per sample so mid-frame toggles cannot tear a frame.
      if (state_q == LOAD) begin
        mode_q <= frame_mode;
        data_q <= ld_ext;
        chb_q  <= ld_chb;
        cs_q   <= ld_cs;
      end
      if (s_strobe && fifo_full && !pop && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  assign uart_data    = (state_q == SEND) ? tx_byte : 8'h00;
  assign overflow_cnt = ovf_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_stream_framer.sv
// Directed bench for adc_stream_framer with a 4-entry FIFO and a UART model
// that answers each en_send with tx_done five cycles later.
module tb_adc_stream_framer;
  import adc_stream_pkg::*;

  localparam int DATA_W     = 12;
  localparam int NUM_CH     = 8;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        s_strobe   = 1'b0;
  logic [11:0] s_data     = 12'h000;
  logic [2:0]  s_ch       = 3'd0;
  logic        frame_mode = 1'b0;
  logic        uart_en_send;
  logic [7:0]  uart_data;
  logic        uart_tx_done;
  logic [2:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic        busy;
  state_e      dbg_state;

  logic model_done = 1'b0;
  logic man_done   = 1'b0;
  logic uart_auto  = 1'b1;
  int   model_cnt  = 0;
  int   cyc        = 0;
  int   last_t     = 0;

  logic [7:0] got_q[$];
  int         got_t_q[$];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign uart_tx_done = model_done | man_done;

  adc_stream_framer #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_strobe     (s_strobe),
    .s_data       (s_data),
    .s_ch         (s_ch),
    .frame_mode   (frame_mode),
    .uart_en_send (uart_en_send),
    .uart_data    (uart_data),
    .uart_tx_done (uart_tx_done),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // UART model: tx_done five cycles after en_send; held off while uart_auto is 0
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!uart_auto) begin
      model_cnt = 0;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_done = 1'b1;
    end
    if (uart_en_send) model_cnt = uart_auto ? 5 : 0;
  end

  // Byte monitor
  always @(negedge clk) begin
    if (uart_en_send) begin
      got_q.push_back(uart_data);
      got_t_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required end before it", $time);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    s_strobe = 1'b1;
    s_ch     = ch;
    s_data   = d;
    last_t   = cyc;
    @(negedge clk);
    s_strobe = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while (got_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (got_q.size() < n) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %h, required %h", name, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (uart_en_send !== 1'b0) begin miscompares++; $display("FAIL rst_en_send: got %b, required 0", uart_en_send); end
    vectors++; if (uart_data !== 8'h00) begin miscompares++; $display("FAIL rst_uart_data: got %h, required 00", uart_data); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
    vectors++; if (overflow_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_overflow: got %0d, required 0", overflow_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_raw();
    logic [7:0] exp_q[$];
    int t;
    frame_mode = 1'b0;
    got_q.delete(); got_t_q.delete();
    strobe(3'd3, 12'hABC);
    t = last_t;
    wait_bytes(2, "raw");
    repeat (10) @(negedge clk);
    exp_q = '{8'h0A, 8'hBC};
    check_bytes("raw", exp_q);
    vectors++; if (got_t_q.size() < 2 || got_t_q[0] !== t + 3) begin miscompares++; $display("FAIL raw_first_latency: got cycle %0d, required %0d", (got_t_q.size() > 0) ? got_t_q[0] : -1, t + 3); end
    vectors++; if (got_t_q.size() < 2 || got_t_q[1] !== t + 9) begin miscompares++; $display("FAIL raw_next_latency: got cycle %0d, required %0d", (got_t_q.size() > 1) ? got_t_q[1] : -1, t + 9); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL raw_level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_framed();
    logic [7:0] exp_q[$];
    int busy_low = 0;
    int k = 0;
    frame_mode = 1'b1;
    got_q.delete(); got_t_q.delete();
    strobe(3'd5, 12'h123);
    // busy must hold from LOAD through the last byte's tx_done cycle
    while (!(got_q.size() == 5 && cyc >= got_t_q[4] + 5) && k < 200) begin
      @(negedge clk);
      k++;
      if (busy !== 1'b1) busy_low++;
    end
    vectors++; if (k >= 200) begin miscompares++; $display("FAIL framed_timeout: got %0d bytes, required 5", got_q.size()); end
    vectors++; if (busy_low != 0) begin miscompares++; $display("FAIL framed_busy: got %0d low cycles, required 0", busy_low); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL framed_busy_end: got %b, required 0", busy); end
    repeat (5) @(negedge clk);
    exp_q = '{8'hA5, 8'h05, 8'h01, 8'h23, 8'h27};
    check_bytes("framed", exp_q);
  endtask

  task automatic test_mode_toggle_back_to_back();
    logic [7:0] exp_q[$];
    int t;
    frame_mode = 1'b1;
    got_q.delete(); got_t_q.delete();
    @(negedge clk);
    s_strobe = 1'b1; s_ch = 3'd2; s_data = 12'h345; t = cyc;
    @(negedge clk);
    s_ch = 3'd7; s_data = 12'hFED;
    @(negedge clk);
    s_strobe = 1'b0;
    wait_bytes(1, "toggle_first");
    frame_mode = 1'b0;
    wait_bytes(7, "toggle");
    repeat (10) @(negedge clk);
    exp_q = '{8'hA5, 8'h02, 8'h03, 8'h45, 8'h44, 8'h0F, 8'hED};
    check_bytes("toggle", exp_q);
    vectors++; if (got_t_q.size() < 1 || got_t_q[0] !== t + 3) begin miscompares++; $display("FAIL toggle_first_latency: got cycle %0d, required %0d", (got_t_q.size() > 0) ? got_t_q[0] : -1, t + 3); end
    vectors++; if (got_t_q.size() < 6 || got_t_q[5] !== got_t_q[4] + 8) begin miscompares++; $display("FAIL frame_gap: got cycle %0d, required %0d", (got_t_q.size() > 5) ? got_t_q[5] : -1, (got_t_q.size() > 4) ? got_t_q[4] + 8 : -1); end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [7:0] exp_q[$];
    int t;
    uart_auto  = 1'b0;
    frame_mode = 1'b0;
    got_q.delete(); got_t_q.delete();
    strobe(3'd0, 12'h0FF);
    t = last_t;
    wait_bytes(1, "ovf_primer");
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      s_strobe = 1'b1;
      s_ch     = 3'(i);
      s_data   = 12'(i * 256 + 16 + i);
    end
    @(negedge clk);
    s_strobe = 1'b0;
    vectors++; if (got_t_q.size() < 1 || got_t_q[0] !== t + 3) begin miscompares++; $display("FAIL ovf_primer_latency: got cycle %0d, required %0d", (got_t_q.size() > 0) ? got_t_q[0] : -1, t + 3); end
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL ovf_level: got %0d, required 4", fifo_level); end
    vectors++; if (overflow_cnt !== 8'd3) begin miscompares++; $display("FAIL ovf_count: got %0d, required 3", overflow_cnt); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_busy: got %b, required 1", busy); end
    // Finish the primer by hand so the pop cycle is known exactly
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    wait_bytes(2, "ovf_primer_b1");
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    s_strobe = 1'b1; s_ch = 3'd6; s_data = 12'hC3D;
    @(negedge clk);
    s_strobe = 1'b0;
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL fullpop_level: got %0d, required 4", fifo_level); end
    vectors++; if (overflow_cnt !== 8'd3) begin miscompares++; $display("FAIL fullpop_overflow: got %0d, required 3", overflow_cnt); end
    uart_auto = 1'b1;
    wait_bytes(12, "ovf_drain");
    repeat (10) @(negedge clk);
    exp_q = '{8'h00, 8'hFF};
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({4'h0, 4'(i)});
      exp_q.push_back({4'h1, 4'(i)});
    end
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h3D);
    check_bytes("ovf_order", exp_q);
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL ovf_drain_level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_q[$];
    int t;
    int n0;
    frame_mode = 1'b1;
    got_q.delete(); got_t_q.delete();
    strobe(3'd1, 12'h456);
    t = last_t;
    wait_bytes(2, "midrst_pre");
    strobe(3'd2, 12'h789);
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL midrst_pre_level: got %0d, required 1", fifo_level); end
    vectors++; if (got_t_q.size() < 2 || got_t_q[1] !== t + 9) begin miscompares++; $display("FAIL midrst_b2_time: got cycle %0d, required %0d", (got_t_q.size() > 1) ? got_t_q[1] : -1, t + 9); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vectors++; if (uart_en_send !== 1'b0 || uart_data !== 8'h00) begin miscompares++; $display("FAIL midrst_outputs: got en=%b data=%h, required en=0 data=00", uart_en_send, uart_data); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL midrst_level: got %0d, required 0", fifo_level); end
    vectors++; if (overflow_cnt !== 8'd0) begin miscompares++; $display("FAIL midrst_overflow: got %0d, required 0", overflow_cnt); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    n0 = got_q.size();
    repeat (20) @(negedge clk);
    vectors++; if (got_q.size() != n0 || n0 != 2) begin miscompares++; $display("FAIL midrst_no_send: got %0d bytes, required 2", got_q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL midrst_state: got %0d, required %0d", dbg_state, IDLE); end
    frame_mode = 1'b0;
    got_q.delete(); got_t_q.delete();
    strobe(3'd4, 12'h9E1);
    wait_bytes(2, "midrst_after");
    repeat (10) @(negedge clk);
    exp_q = '{8'h09, 8'hE1};
    check_bytes("midrst_after", exp_q);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_raw();
    test_framed();
    test_mode_toggle_back_to_back();
    test_overflow_and_full_pop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
